imm_ext_unit: RTL and testbench
===============================

# imm_ext_unit

Registered, parametrised immediate generator placed between instruction decode and the execute operand mux. Selects a SHORT_W-bit or IMM_W-bit field from the incoming constant and applies one of four extension modes to produce a DATA_W-bit operand. Results pass through a 2-entry ready/valid output buffer, so decode and execute can stall independently without losing or duplicating immediates.

## Interface
- DATA_W, 32, output operand width; must be greater than IMM_W
- IMM_W, 12, full constant field width (rs+rt)
- SHORT_W, 6, short constant field width (rt); must be less than IMM_W
- SHL, 1, left-shift amount for mode 3; 0 to DATA_W-IMM_W
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_const  in  IMM_W  raw constant field; short form uses bits [SHORT_W-1:0]
- in_mode  in  2  extension mode (see Operation)
- in_valid  in  1  in_const/in_mode valid this cycle
- in_ready  out  1  unit can accept an input this cycle
- out_imm  out  DATA_W  extended immediate at the buffer head
- out_valid  out  1  out_imm valid
- out_ready  in  1  consumer accepts out_imm this cycle

## Operation
- Modes:
  - 0: sign-extend const[SHORT_W-1:0].
  - 1: sign-extend const[IMM_W-1:0].
  - 2: zero-extend const[IMM_W-1:0].
  - 3: sign-extend const[IMM_W-1:0], then shift left by SHL with zero fill. Bits shifted past DATA_W-1 are discarded.
- Extension is combinational on the inputs. The result is written into the buffer on an accept.
- Accept: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- Buffer: 2-entry FIFO with head and tail pointers (1 bit each) and a count (0..2). States:
  - EMPTY (count 0): out_valid=0, in_ready=1.
  - ONE (count 1): out_valid=1, in_ready=1.
  - FULL (count 2): out_valid=1, in_ready=0.
- Transitions:
  - EMPTY: accept goes to ONE.
  - ONE: accept only goes to FULL; pop only goes to EMPTY; accept and pop together stays in ONE, with the new entry becoming the head on the next cycle.
  - FULL: pop goes to ONE. An accept is impossible because in_ready=0.
- Ordering is strict FIFO.
- in_ready depends only on registered state (no combinational path from out_ready). out_imm and out_valid also depend only on registered state.
- in_valid while in_ready=0: ignored, nothing written. The producer must hold its input stable.
- Out-of-range parameters are rejected at elaboration (generate-time $error).

## Timing
- Reset (asynchronous assert, synchronous release):
  - count=0, pointers=0, both buffer entries=0.
  - out_valid=0, out_imm=0, in_ready=1.
- Latency: input accepted at edge N appears at out_imm with out_valid=1 after edge N, when the buffer was empty.
- Throughput: 1 immediate per cycle while out_ready=1.
- Asserting reset_n low mid-operation flushes both entries immediately. out_valid drops in the same cycle, without waiting for a clock edge.

## Configuration
- IMM_EXT_STATS_EN:
  - Defined: adds an output port imm_count [31:0], reset to 0. It increments by 1 on each pop and saturates at 32'hFFFF_FFFF (no wrap).
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then idle: out_valid=0, out_imm=0, in_ready=1. Hold reset_n low for 3 cycles mid-stream with count=2: out_valid goes low immediately and nothing drains after release.
- Modes with DATA_W=32, IMM_W=12, SHORT_W=6, SHL=1:
  - in_const=12'h03F, mode 0 -> 32'hFFFF_FFFF.
  - in_const=12'h81F, mode 1 -> 32'hFFFF_F81F.
  - in_const=12'h81F, mode 2 -> 32'h0000_081F.
  - in_const=12'h800, mode 3 -> 32'hFFFF_F000.
- Backpressure: out_ready=0 while 3 inputs are offered back to back. Exactly 2 are accepted, and in_ready=0 from the cycle after the second accept. After out_ready=1, the outputs appear in input order and the third input is then accepted.
- Simultaneous accept and pop at count=1 for 10 cycles: count stays 1, with one output per cycle in order and no drops or duplicates.
- Random valid/ready over 1000 transactions with a scoreboard: every accepted immediate is output exactly once, in order, with correct extension.
- With IMM_EXT_STATS_EN: after 5 pops, imm_count=5. Force the counter to 32'hFFFF_FFFF; one more pop leaves it at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/imm_ext_unit.sv
// Immediate extension unit: selects a short or full constant field, applies one of four
// extension modes and queues the result in a 2-entry ready/valid buffer. Optional: IMM_EXT_STATS_EN.
module imm_ext_unit #(
   parameter int DATA_W  = 32,
   parameter int IMM_W   = 12,
   parameter int SHORT_W = 6,
   parameter int SHL     = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [IMM_W-1:0]  in_const,
   input  logic [1:0]        in_mode,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_imm,
   output logic              out_valid,
   input  logic              out_ready
`ifdef IMM_EXT_STATS_EN
   ,
   output logic [31:0]       imm_count
`endif
);

   if (DATA_W <= IMM_W) begin : g_bad_data_w
      $error("imm_ext_unit: DATA_W must be greater than IMM_W");
   end
   if ((SHORT_W < 1) || (SHORT_W >= IMM_W)) begin : g_bad_short_w
      $error("imm_ext_unit: SHORT_W must be in 1..IMM_W-1");
   end
   if ((SHL < 0) || (SHL > (DATA_W - IMM_W))) begin : g_bad_shl
      $error("imm_ext_unit: SHL must be in 0..DATA_W-IMM_W");
   end

   logic [DATA_W-1:0] w_sext_short;
   logic [DATA_W-1:0] w_sext_full;
   logic [DATA_W-1:0] w_zext_full;
   logic [DATA_W-1:0] w_shl_full;
   logic [DATA_W-1:0] w_ext;
   logic              w_push;
   logic              w_pop;
   logic [1:0]        w_count_nxt;

   logic [DATA_W-1:0] r_mem [0:1];
   logic              r_head;
   logic              r_tail;
   logic [1:0]        r_count;
   logic              r_out_valid;
   logic              r_in_ready;

   assign w_sext_short = {{(DATA_W-SHORT_W){in_const[SHORT_W-1]}}, in_const[SHORT_W-1:0]};
   assign w_sext_full  = {{(DATA_W-IMM_W){in_const[IMM_W-1]}}, in_const};
   assign w_zext_full  = {{(DATA_W-IMM_W){1'b0}}, in_const};
   assign w_shl_full   = w_sext_full << SHL;

   // Extension mode select
   always_comb begin
      w_ext = {DATA_W{1'b0}};
      case (in_mode)
         2'd0:    w_ext = w_sext_short;
         2'd1:    w_ext = w_sext_full;
         2'd2:    w_ext = w_zext_full;
         2'd3:    w_ext = w_shl_full;
         default: w_ext = {DATA_W{1'b0}};
      endcase
   end

   // Handshakes use only registered flags, so in_ready never depends on out_ready
   assign w_push = in_valid && r_in_ready;
   assign w_pop  = r_out_valid && out_ready;

   // Next occupancy from the push/pop pair
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         2'b11:   w_count_nxt = r_count;
         2'b00:   w_count_nxt = r_count;
         default: w_count_nxt = r_count;
      endcase
   end

   // Buffer storage, pointers and registered handshake flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mem[0]    <= {DATA_W{1'b0}};
         r_mem[1]    <= {DATA_W{1'b0}};
         r_head      <= 1'b0;
         r_tail      <= 1'b0;
         r_count     <= 2'd0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= w_ext;
            r_tail        <= ~r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         r_count     <= w_count_nxt;
         r_out_valid <= (w_count_nxt != 2'd0);
         r_in_ready  <= (w_count_nxt != 2'd2);
      end
   end

   assign out_imm   = r_mem[r_head];
   assign out_valid = r_out_valid;
   assign in_ready  = r_in_ready;

`ifdef IMM_EXT_STATS_EN
   logic [31:0] r_imm_count;

   // Saturating pop counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_imm_count <= 32'd0;
      end else if (w_pop && (r_imm_count != 32'hFFFF_FFFF)) begin
         r_imm_count <= r_imm_count + 32'd1;
      end
   end

   assign imm_count = r_imm_count;
`endif

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed and randomised self-checking bench for imm_ext_unit (DATA_W=32, IMM_W=12, SHORT_W=6, SHL=1).
module tb_imm_ext_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [11:0] in_const;
   logic [1:0]  in_mode;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_imm;
   logic        out_valid;
   logic        out_ready;
`ifdef IMM_EXT_STATS_EN
   logic [31:0] imm_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   imm_ext_unit #(.DATA_W(32), .IMM_W(12), .SHORT_W(6), .SHL(1)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_const  (in_const),
      .in_mode   (in_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_imm   (out_imm),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef IMM_EXT_STATS_EN
      ,
      .imm_count (imm_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference extension, written with signed casts rather than bit replication
   function automatic logic [31:0] exp_imm(input logic [11:0] c, input logic [1:0] m);
      logic [5:0] s;
      int         v;
      s = c[5:0];
      case (m)
         2'd0:    v = int'($signed(s));
         2'd1:    v = int'($signed(c));
         2'd2:    v = int'({20'd0, c});
         default: v = int'($signed(c)) * 2;
      endcase
      return 32'(v);
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; in_const = 12'd0; in_mode = 2'd0; out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b1;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (out_imm !== 32'd0) begin n_err++; $display("FAIL reset_out_imm: got %h expected 00000000", out_imm); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      repeat (2) tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_modes();
      logic [11:0] c_tab [10] = '{12'h03F, 12'h81F, 12'h81F, 12'h800, 12'h020,
                                  12'hFDF, 12'h7FF, 12'hFFF, 12'h7FF, 12'hFFF};
      logic [1:0]  m_tab [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      logic [31:0] e_tab [10] = '{32'hFFFF_FFFF, 32'hFFFF_F81F, 32'h0000_081F, 32'hFFFF_F000,
                                  32'hFFFF_FFE0, 32'h0000_001F, 32'h0000_07FF, 32'h0000_0FFF,
                                  32'h0000_0FFE, 32'hFFFF_FFFE};
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_const = c_tab[i]; in_mode = m_tab[i]; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         n_vec++;
         if (out_valid !== 1'b1 || out_imm !== e_tab[i]) begin
            n_err++;
            $display("FAIL mode_vec%0d: got valid=%b imm=%h expected valid=1 imm=%h", i, out_valid, out_imm, e_tab[i]);
         end
         tick();
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mode_drain%0d: got valid=%b expected 0", i, out_valid); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e0, e1, e2;
      e0 = 32'h0000_0123; e1 = 32'hFFFF_FFF5; e2 = 32'h0000_0ABC;
      out_ready = 1'b0;
      in_const = 12'h123; in_mode = 2'd1; in_valid = 1'b1;
      tick();
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_imm !== e0) begin
         n_err++; $display("FAIL bp_first: got rdy=%b vld=%b imm=%h expected 1 1 %h", in_ready, out_valid, out_imm, e0); end
      in_const = 12'hF75; in_mode = 2'd0;
      tick();
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
      in_const = 12'hABC; in_mode = 2'd2;
      tick();
      n_vec++; if (in_ready !== 1'b0 || out_imm !== e0) begin
         n_err++; $display("FAIL bp_held: got rdy=%b imm=%h expected 0 %h", in_ready, out_imm, e0); end
      out_ready = 1'b1;
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_imm !== e1 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_second: got vld=%b imm=%h rdy=%b expected 1 %h 1", out_valid, out_imm, in_ready, e1); end
      tick();
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_imm !== e2) begin
         n_err++; $display("FAIL bp_third: got vld=%b imm=%h expected 1 %h", out_valid, out_imm, e2); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_simultaneous();
      logic [11:0] c [11];
      logic [1:0]  m [11];
      for (int i = 0; i < 11; i++) begin
         c[i] = 12'(12'h0A5 + i * 12'd337);
         m[i] = 2'(i);
      end
      out_ready = 1'b1;
      in_const = c[0]; in_mode = m[0]; in_valid = 1'b1;
      tick();
      for (int i = 1; i < 11; i++) begin
         n_vec++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_imm !== exp_imm(c[i-1], m[i-1])) begin
            n_err++;
            $display("FAIL simul_%0d: got vld=%b rdy=%b imm=%h expected 1 1 %h", i, out_valid, in_ready, out_imm, exp_imm(c[i-1], m[i-1]));
         end
         in_const = c[i]; in_mode = m[i];
         tick();
      end
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_imm !== exp_imm(c[10], m[10])) begin
         n_err++; $display("FAIL simul_last: got vld=%b imm=%h expected 1 %h", out_valid, out_imm, exp_imm(c[10], m[10])); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_random();
      logic [31:0] q [$];
      logic [31:0] e;
      int          acc_n = 0;
      int          cyc = 0;
      logic        accepted;
      in_valid = 1'b0;
      while (acc_n < 1000 && cyc < 10000) begin
         if (!in_valid && $urandom_range(0, 9) < 7) begin
            in_valid = 1'b1; in_const = 12'($urandom); in_mode = 2'($urandom);
         end
         out_ready = ($urandom_range(0, 9) < 7);
         n_vec++;
         if (out_valid !== 1'(q.size() != 0)) begin
            n_err++; $display("FAIL rand_valid cyc%0d: got %b expected %b", cyc, out_valid, q.size() != 0);
         end
         if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            if (out_imm !== e) begin n_err++; $display("FAIL rand_data cyc%0d: got %h expected %h", cyc, out_imm, e); end
         end
         accepted = in_valid && in_ready;
         if (accepted) begin
            q.push_back(exp_imm(in_const, in_mode));
            acc_n++;
         end
         tick();
         cyc++;
         if (accepted) in_valid = 1'b0;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4 && q.size() != 0; k++) begin
         e = q.pop_front();
         n_vec++;
         if (out_valid !== 1'b1 || out_imm !== e) begin
            n_err++; $display("FAIL rand_drain: got vld=%b imm=%h expected 1 %h", out_valid, out_imm, e);
         end
         tick();
      end
      n_vec++; if (acc_n != 1000 || q.size() != 0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL rand_end: got accepted=%0d left=%0d vld=%b expected 1000 0 0", acc_n, q.size(), out_valid); end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      in_const = 12'h555; in_mode = 2'd2; in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_err++; $display("FAIL mid_full: got rdy=%b vld=%b expected 0 1", in_ready, out_valid); end
      #2 reset_n = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0 || out_imm !== 32'd0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL mid_async: got vld=%b imm=%h rdy=%b expected 0 00000000 1", out_valid, out_imm, in_ready); end
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_nodrain%0d: got %b expected 0", k, out_valid); end
      end
   endtask

`ifdef IMM_EXT_STATS_EN
   task automatic test_stats();
      #2 reset_n = 1'b0;
      #3 reset_n = 1'b1;
      out_ready = 1'b1;
      in_const = 12'h011; in_mode = 2'd1; in_valid = 1'b1;
      tick();
      repeat (4) tick();
      in_valid = 1'b0;
      tick();
      n_vec++; if (imm_count !== 32'd5) begin n_err++; $display("FAIL stats_five: got %0d expected 5", imm_count); end
      force dut.r_imm_count = 32'hFFFF_FFFF;
      #1 release dut.r_imm_count;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      n_vec++; if (imm_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL stats_sat: got %h expected ffffffff", imm_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_modes();
      test_backpressure();
      test_simultaneous();
      test_random();
      test_reset_midstream();
`ifdef IMM_EXT_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
